// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI-stream packet FIFO.
// A stored entry is the packed beat {tlast, dest, user, data}.
package axis_fifo_pkg;

  function automatic int axis_fifo_entry_width(input int data_width,
                                               input int user_width,
                                               input int dest_width);
    return data_width + user_width + dest_width + 1;
  endfunction

endpackage

// File: rtl/axi_stream.sv
// AXI-stream bundle used between datapath blocks.
// The master drives the beat and valid; the slave drives ready.
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32,
  parameter int DEST_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [USER_WIDTH-1:0] user;
  logic [DEST_WIDTH-1:0] dest;
  logic                  tlast;

  modport master (output valid, data, user, dest, tlast, input ready);
  modport slave  (input valid, data, user, dest, tlast, output ready);
endinterface

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read.
// Contents are never cleared; the pointers in the top level decide what is valid.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ENTRY_WIDTH = axis_fifo_entry_width(32, 32, 32)
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_WIDTH-1:0]   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_WIDTH-1:0]   rdata
);
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_packet_fifo.sv
// AXI-stream circular buffer with optional store-and-forward packet mode.
// Holds pointers, occupancy counters, the cut-through flag and handshakes.
module axis_packet_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 32,
  parameter int DEST_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  axi_stream.slave               in,
  axi_stream.master              out,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [$clog2(DEPTH):0] packets_stored
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = axis_fifo_entry_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          cut_through;
  logic          full;
  logic          cut_active;
  logic          push;
  logic          pop;
  logic          push_last;
  logic          pop_last;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign full     = (fill_level == FULL_LEVEL);
  assign in.ready = reset && !full;

  // A full buffer with no tlast stored can never complete a packet, so it
  // streams out immediately instead of waiting a cycle for the flag.
  assign cut_active = cut_through || (full && packets_stored == '0);
  assign out.valid  = (fill_level != '0) &&
                      ((PACKET_MODE == 0) || (packets_stored != '0) || cut_active);

  assign push      = in.valid && in.ready;
  assign pop       = out.valid && out.ready;
  assign push_last = push && in.tlast;
  assign pop_last  = pop && out.tlast;

  assign wr_entry  = {in.tlast, in.dest, in.user, in.data};
  assign out.data  = rd_entry[DATA_WIDTH-1:0];
  assign out.user  = rd_entry[DATA_WIDTH +: USER_WIDTH];
  assign out.dest  = rd_entry[DATA_WIDTH+USER_WIDTH +: DEST_WIDTH];
  assign out.tlast = rd_entry[EW-1];

  axis_fifo_ram #(
    .DEPTH       (DEPTH),
    .ENTRY_WIDTH (EW)
  ) u_ram (
    .clock (clock),
    .we    (push && !flush),
    .waddr (wp),
    .wdata (wr_entry),
    .raddr (rp),
    .rdata (rd_entry)
  );

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wp             <= '0;
      rp             <= '0;
      fill_level     <= '0;
      packets_stored <= '0;
      cut_through    <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;

      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase

      case ({push_last, pop_last})
        2'b10:   packets_stored <= packets_stored + 1'b1;
        2'b01:   packets_stored <= packets_stored - 1'b1;
        default: packets_stored <= packets_stored;
      endcase

      if (pop_last)                           cut_through <= 1'b0;
      else if (full && packets_stored == '0)  cut_through <= 1'b1;
    end
  end
endmodule
